// File: rtl/macc_pkg.sv
// Shared definitions for the matrix operand buffers.
//   - state_t   : buffer controller states (IDLE/LOAD/FULL/DRAIN)
//   - ORDER_*   : read-order select values (row-major / column-major)
//   - DEFAULT_* : default element width and index width
// No ports; imported by the interface, address generator and top.
package macc_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DIM_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic ORDER_ROW = 1'b0;
    localparam logic ORDER_COL = 1'b1;

endpackage

// File: rtl/matrix_buf_if.sv
// Stream bundle between a matrix buffer and its producer/consumer.
//   wr_valid/wr_ready/wr_data         : row-major load stream into the buffer
//   rd_valid/rd_ready/rd_data/rd_last : read stream out of the buffer
// Modports:
//   master : the side that feeds writes and consumes reads
//   slave  : the buffer itself
interface matrix_buf_if
    import macc_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, rd_last
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, rd_last
    );

endinterface

// File: rtl/matrix_addr_gen.sv
// Row/column address counter for one side (write or read) of a matrix buffer.
// Ports:
//   CLK, RST          : clock, synchronous active-high reset
//   clear             : restart at (0,0)
//   step              : advance to the next element in the selected order
//   rows_m1, cols_m1  : matrix dimensions minus one
//   order             : ORDER_ROW (col fastest) or ORDER_COL (row fastest)
//   addr              : {row, col} of the current element
//   last              : current element is (rows_m1, cols_m1)
// Macro MACC_TRANSPOSE_EN: when undefined the column-major path is absent and
// order is ignored.
module matrix_addr_gen
    import macc_pkg::*;
#(
    parameter int DIM_W = DEFAULT_DIM_W
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               clear,
    input  logic               step,
    input  logic [DIM_W-1:0]   rows_m1,
    input  logic [DIM_W-1:0]   cols_m1,
    input  logic               order,
    output logic [2*DIM_W-1:0] addr,
    output logic               last
);

    logic [DIM_W-1:0] row;
    logic [DIM_W-1:0] col;
    logic [DIM_W-1:0] row_next;
    logic [DIM_W-1:0] col_next;
    logic             row_end;
    logic             col_end;

    assign row_end = (row == rows_m1);
    assign col_end = (col == cols_m1);
    assign last    = row_end && col_end;
    assign addr    = {row, col};

    always_comb begin
        row_next = row;
        col_next = col;
`ifdef MACC_TRANSPOSE_EN
        if (order == ORDER_COL) begin
            if (row_end) begin
                row_next = '0;
                col_next = col_end ? '0 : col + 1'b1;
            end else begin
                row_next = row + 1'b1;
            end
        end else
`endif
        begin
            if (col_end) begin
                col_next = '0;
                row_next = row_end ? '0 : row + 1'b1;
            end else begin
                col_next = col + 1'b1;
            end
        end
    end

`ifndef MACC_TRANSPOSE_EN
    logic unused_order;
    assign unused_order = order;
`endif

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            row <= '0;
            col <= '0;
        end else if (step) begin
            row <= row_next;
            col <= col_next;
        end
    end

endmodule

// File: rtl/matrix_buf.sv
// Single-matrix operand buffer: loads a matrix row-major over a valid/ready
// stream, then streams it out any number of times, row-major or transposed.
// Ports:
//   CLK, RST                 : clock, synchronous active-high reset
//   cfg_rows_m1, cfg_cols_m1 : dimensions minus one, sampled on accepted load_start
//   load_start               : begin load (accepted in IDLE or FULL)
//   rd_start                 : begin read pass (accepted in FULL only)
//   rd_transpose             : 1 = column-major read, sampled with rd_start
//   full                     : a complete matrix is held
//   busy                     : loading or draining
//   bus (slave)              : wr_* load stream and rd_* read stream
// Macro MACC_TRANSPOSE_EN: enables column-major reads; when undefined
// rd_transpose is ignored.
module matrix_buf
    import macc_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DIM_W  = DEFAULT_DIM_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [DIM_W-1:0] cfg_rows_m1,
    input  logic [DIM_W-1:0] cfg_cols_m1,
    input  logic             load_start,
    input  logic             rd_start,
    input  logic             rd_transpose,
    output logic             full,
    output logic             busy,
    matrix_buf_if.slave      bus
);

    localparam int AW    = 2 * DIM_W;
    localparam int DEPTH = 1 << AW;

    state_t state;
    state_t state_next;

    logic [DIM_W-1:0]  rows_m1_q;
    logic [DIM_W-1:0]  cols_m1_q;
    logic              order_q;
    logic              load_go;
    logic              read_go;
    logic              wr_fire;
    logic              pop;
    logic              issue;
    logic              issue_done;
    logic              inflight;
    logic              inflight_last;
    logic [2:0]        occupancy;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;
    logic              wr_last;
    logic              rd_addr_last;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] q_data0;
    logic [DATA_W-1:0] q_data1;
    logic              q_last0;
    logic              q_last1;
    logic [1:0]        q_count;

    assign bus.wr_ready = (state == LOAD);
    assign bus.rd_valid = (q_count != 2'd0);
    assign bus.rd_data  = q_data0;
    assign bus.rd_last  = q_last0;
    assign full         = (state == FULL);
    assign busy         = (state == LOAD) || (state == DRAIN);

    assign wr_fire = bus.wr_valid && bus.wr_ready;
    assign pop     = bus.rd_valid && bus.rd_ready;

    // Slots the queue will need once the in-flight read lands, after this
    // cycle's pop. A new read may issue only if that leaves room for it.
    assign occupancy = {1'b0, q_count} - {2'b00, pop} + {2'b00, inflight};
    assign issue     = (state == DRAIN) && !issue_done && (occupancy <= 3'd1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_go    = 1'b0;
        read_go    = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    load_go    = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (wr_fire && wr_last) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (load_start) begin
                    load_go    = 1'b1;
                    state_next = LOAD;
                end else if (rd_start) begin
                    read_go    = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && q_last0) begin
                    state_next = FULL;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rows_m1_q <= '0;
            cols_m1_q <= '0;
        end else if (load_go) begin
            rows_m1_q <= cfg_rows_m1;
            cols_m1_q <= cfg_cols_m1;
        end
    end

`ifdef MACC_TRANSPOSE_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            order_q <= ORDER_ROW;
        end else if (read_go) begin
            order_q <= rd_transpose;
        end
    end
`else
    logic unused_transpose;
    assign unused_transpose = rd_transpose;
    assign order_q          = ORDER_ROW;
`endif

    matrix_addr_gen #(.DIM_W(DIM_W)) u_wr_gen (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (load_go),
        .step    (wr_fire),
        .rows_m1 (rows_m1_q),
        .cols_m1 (cols_m1_q),
        .order   (ORDER_ROW),
        .addr    (wr_addr),
        .last    (wr_last)
    );

    matrix_addr_gen #(.DIM_W(DIM_W)) u_rd_gen (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (read_go),
        .step    (issue),
        .rows_m1 (rows_m1_q),
        .cols_m1 (cols_m1_q),
        .order   (order_q),
        .addr    (rd_addr),
        .last    (rd_addr_last)
    );

    // Storage: no reset so it maps onto block RAM.
    always_ff @(posedge CLK) begin
        if (wr_fire) begin
            mem[wr_addr] <= bus.wr_data;
        end
        if (issue) begin
            ram_rdata <= mem[rd_addr];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            issue_done    <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && rd_addr_last;
            if (read_go) begin
                issue_done <= 1'b0;
            end else if (issue && rd_addr_last) begin
                issue_done <= 1'b1;
            end
        end
    end

    // Two-entry skid queue; entry 0 drives rd_data/rd_last and only changes
    // on a pop or when the queue is empty.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_data0 <= '0;
            q_data1 <= '0;
            q_last0 <= 1'b0;
            q_last1 <= 1'b0;
            q_count <= 2'd0;
        end else begin
            case ({inflight, pop})
                2'b11: begin
                    if (q_count == 2'd1) begin
                        q_data0 <= ram_rdata;
                        q_last0 <= inflight_last;
                    end else begin
                        q_data0 <= q_data1;
                        q_last0 <= q_last1;
                        q_data1 <= ram_rdata;
                        q_last1 <= inflight_last;
                    end
                end
                2'b01: begin
                    q_data0 <= q_data1;
                    q_last0 <= q_last1;
                    q_count <= q_count - 2'd1;
                end
                2'b10: begin
                    if (q_count == 2'd0) begin
                        q_data0 <= ram_rdata;
                        q_last0 <= inflight_last;
                    end else begin
                        q_data1 <= ram_rdata;
                        q_last1 <= inflight_last;
                    end
                    q_count <= q_count + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
